dm_responder: RTL and testbench

Data-memory responder for the 5-stage MIPS core: services load/store requests from the MEM stage over a valid/ready request channel and a one-cycle response pulse, with configurable wait states. It holds the 4 KB data array internally and performs word/halfword/byte stores with lane merging, so the core can move from a zero-latency data memory to a stalling memory port.

---
 rtl/dm_resp_pkg.sv | 17 +
 rtl/dm_lane_merge.sv | 39 +++
 rtl/dm_responder.sv | 137 +++++++++++++
 tb/tb_dm_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_resp_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-state counter width.
package dm_resp_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_lane_merge.sv
// Little-endian store lane merge. The old word passes through unchanged when the
// store is misaligned or uses the reserved size code.
module dm_lane_merge
  import dm_resp_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  output logic [31:0] merged,
  output logic        misalign
);

  always_comb begin
    merged   = oldWord;
    misalign = 1'b0;
    case (size)
      SZ_WORD: begin
        if (addrLo != 2'b00) misalign = 1'b1;
        else                 merged   = wdata;
      end
      SZ_HALF: begin
        if (addrLo[0])      misalign      = 1'b1;
        else if (addrLo[1]) merged[31:16] = wdata[15:0];
        else                merged[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        case (addrLo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready request channel, programmable wait states,
// one-cycle response pulse, internal word array with byte/halfword store merging.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic              enterResp;

  logic              wrQ;
  logic [11:0]       addrQ;
  logic [31:0]       wdataQ;
  logic [1:0]        sizeQ;

  logic              curWr;
  logic [11:0]       curAddr;
  logic [31:0]       curWdata;
  logic [1:0]        curSize;
  logic [AW-1:0]     curIdx;
  logic [31:0]       oldWord;
  logic [31:0]       merged;
  logic              misalign;
  logic              outOfRange;
  logic              accessErr;

  logic [31:0]       mem [DEPTH_WORDS];

  // With zero wait states the access happens on the accept edge itself, so the
  // live request is used; otherwise the latched copy is.
  always_comb begin
    if (state == ST_IDLE) begin
      curWr    = req_wr;
      curAddr  = req_addr;
      curWdata = req_wdata;
      curSize  = req_size;
    end else begin
      curWr    = wrQ;
      curAddr  = addrQ;
      curWdata = wdataQ;
      curSize  = sizeQ;
    end
  end

  assign curIdx     = curAddr[2 +: AW];
  assign oldWord    = mem[curIdx];
  assign outOfRange = (32'(curAddr) >= 32'(DEPTH_WORDS) * 32'd4);
  assign accessErr  = outOfRange | (curWr ? misalign : (curAddr[1:0] != 2'b00));

  dm_lane_merge uMerge (
    .oldWord  (oldWord),
    .wdata    (curWdata),
    .addrLo   (curAddr[1:0]),
    .size     (curSize),
    .merged   (merged),
    .misalign (misalign)
  );

  always_comb begin
    stateNext = state;
    enterResp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            stateNext = ST_RESP;
            enterResp = 1'b1;
          end else begin
            stateNext = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt <= CNT_W'(1)) begin
          stateNext = ST_RESP;
          enterResp = 1'b1;
        end
      end
      ST_RESP: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == ST_IDLE && req_valid) cnt <= CNT_W'(WAIT_CYCLES);
      else if (state == ST_WAIT)         cnt <= cnt - 1'b1;
      if (enterResp) begin
        resp_err   <= accessErr;
        resp_rdata <= (curWr || accessErr) ? 32'd0 : oldWord;
      end
    end
  end

  // Request fields are data only: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      wrQ    <= req_wr;
      addrQ  <= req_addr;
      wdataQ <= req_wdata;
      sizeQ  <= req_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enterResp && curWr && !accessErr) mem[curIdx] <= merged;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed and randomized bench for dm_responder against a byte-array reference model.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_wr;
  logic [11:0] z_req_addr;
  logic [31:0] z_req_wdata;
  logic [1:0]  z_req_size;
  logic        z_resp_valid, z_resp_err, z_busy;
  logic [31:0] z_resp_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl [0:63];

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_wr(z_req_wr), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size),
    .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: memory as bytes, stores write n consecutive bytes little-endian.
  task automatic model(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, output logic [31:0] expR, output logic expE);
    int n;
    n = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
    if (wr) expE = (size == 2'd3) || ((addr % n) != 0);
    else    expE = (addr % 4) != 0;
    expR = 32'd0;
    if (!expE) begin
      if (wr) for (int b = 0; b < n; b++) mdl[addr + b] = wdata[8*b +: 8];
      else    for (int b = 0; b < 4; b++) expR[8*b +: 8] = mdl[addr + b];
    end
  endtask

  task automatic doReq(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, output logic [31:0] rdata, output logic err,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = 12'($urandom);
    req_wdata = $urandom;
    req_size  = 2'($urandom);
    lat   = -1;
    rdata = 'x;
    err   = 1'bx;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat   = n;
        rdata = resp_rdata;
        err   = resp_err;
        break;
      end
    end
  endtask

  task automatic step(input string tag, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] er, r;
    logic        ee, e;
    int          lat;
    model(wr, addr, wdata, size, er, ee);
    doReq(wr, addr, wdata, size, r, e, lat);
    chk({tag, "_rdata"}, r, er);
    chk({tag, "_err"}, 32'(e), 32'(ee));
    chk({tag, "_lat"}, lat, 3);
  endtask

  initial begin
    logic [31:0] lastW, heldR;
    logic        prevReady;
    int          respCount, seen;

    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    z_req_valid = 1'b0; z_req_wr = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Zero wait states, valid held high: one accept every two cycles.
    z_req_wr = 1'b1; z_req_addr = 12'h000; z_req_size = 2'b00;
    z_req_wdata = $urandom; lastW = z_req_wdata; z_req_valid = 1'b1;
    prevReady = 1'b1;
    respCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("z_valid", 32'(z_resp_valid), 32'(prevReady));
      chk("z_ready", 32'(z_req_ready), 32'(!z_resp_valid));
      if (z_resp_valid) respCount++;
      prevReady = z_req_ready;
      if (i < 11 && z_req_ready) begin
        z_req_wdata = $urandom;
        lastW = z_req_wdata;
      end
    end
    z_req_valid = 1'b0;
    chk("z_rate", respCount, 6);
    @(negedge clk);
    z_req_wr = 1'b0; z_req_valid = 1'b1;
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_ld_valid", 32'(z_resp_valid), 32'd1);
    chk("z_ld_rdata", z_resp_rdata, lastW);
    chk("z_ld_err", 32'(z_resp_err), 32'd0);

    for (int w = 0; w < 16; w++) step("init", 1'b1, 12'(4 * w), $urandom, 2'b00);

    step("st_word", 1'b1, 12'h010, 32'h12345678, 2'b00);
    step("ld_word", 1'b0, 12'h010, 32'h0, 2'b00);
    heldR = resp_rdata;
    @(negedge clk);
    chk("hold_valid", 32'(resp_valid), 32'd0);
    chk("hold_rdata", resp_rdata, heldR);
    step("st_byte", 1'b1, 12'h013, 32'h000000AB, 2'b10);
    step("st_half", 1'b1, 12'h010, 32'h0000BEEF, 2'b01);
    step("ld_merge", 1'b0, 12'h010, 32'h0, 2'b11);
    chk("merge_val", resp_rdata, 32'hAB34BEEF);
    step("half_mis", 1'b1, 12'h011, 32'h5555AAAA, 2'b01);
    step("word_mis", 1'b1, 12'h012, 32'h5555AAAA, 2'b00);
    step("rsv_size", 1'b1, 12'h014, 32'h5555AAAA, 2'b11);
    step("ld_mis", 1'b0, 12'h016, 32'h0, 2'b00);
    step("ld_after", 1'b0, 12'h010, 32'h0, 2'b00);
    step("st_sample", 1'b1, 12'h018, 32'hCAFEF00D, 2'b00);
    step("ld_sample", 1'b0, 12'h018, 32'h0, 2'b00);

    // Reset asserted during WAIT drops the store.
    step("st_prior", 1'b1, 12'h020, 32'h11111111, 2'b00);
    @(negedge clk);
    seen = 0;
    while (!req_ready && seen < 30) begin
      @(negedge clk);
      seen++;
    end
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 12'h020; req_wdata = 32'hFFFFFFFF; req_size = 2'b00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_ready", 32'(req_ready), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    chk("mrst_noresp", seen, 0);
    step("ld_prior", 1'b0, 12'h020, 32'h0, 2'b00);

    for (int k = 0; k < 40; k++)
      step("rand", 1'($urandom), 12'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
